// File: rtl/fetchflare_stride_trainer.sv
// Stride-training table: snoops demand-miss addresses, learns one line stride per region
// and emits a single prefetch descriptor once a stream's confidence reaches the threshold.
module fetchflare_stride_trainer #(
  parameter int NUM_ENTRIES    = 32,
  parameter int ADDR_WIDTH     = 49,
  parameter int LINE_BITS      = 6,
  parameter int REGION_BITS    = 12,
  parameter int CONF_WIDTH     = 2,
  parameter int PF_NLINES      = 4,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              enable_i,
  input  logic                              flush_i,
  input  logic [CONF_WIDTH-1:0]             conf_threshold_i,
  input  logic                              snoop_valid_i,
  input  logic [ADDR_WIDTH-1:0]             snoop_addr_i,
  output logic                              req_valid_o,
  input  logic                              req_ready_i,
  output logic [ADDR_WIDTH-LINE_BITS-1:0]   req_base_o,
  output logic [REGION_BITS-LINE_BITS:0]    req_stride_o,
  output logic [15:0]                       req_nlines_o,
  output logic [DROP_CNT_WIDTH-1:0]         drop_cnt_o
);

  localparam int OFF_W  = REGION_BITS - LINE_BITS;
  localparam int STR_W  = OFF_W + 1;
  localparam int TAG_W  = ADDR_WIDTH - REGION_BITS;
  localparam int LINE_W = ADDR_WIDTH - LINE_BITS;
  localparam int AGE_W  = $clog2(NUM_ENTRIES);
  localparam logic [AGE_W-1:0]      AGE_MAX  = AGE_W'(NUM_ENTRIES - 1);
  localparam logic [CONF_WIDTH-1:0] CONF_MAX = '1;

  logic                  r_valid   [NUM_ENTRIES];
  logic [TAG_W-1:0]      r_tag     [NUM_ENTRIES];
  logic [OFF_W-1:0]      r_lastOff [NUM_ENTRIES];
  logic [STR_W-1:0]      r_stride  [NUM_ENTRIES];
  logic [CONF_WIDTH-1:0] r_conf    [NUM_ENTRIES];
  logic [AGE_W-1:0]      r_age     [NUM_ENTRIES];

  logic                      r_reqValid;
  logic [LINE_W-1:0]         r_reqBase;
  logic [STR_W-1:0]          r_reqStride;
  logic [DROP_CNT_WIDTH-1:0] r_dropCnt;

  logic [TAG_W-1:0]      w_tag;
  logic [OFF_W-1:0]      w_off;
  logic [LINE_W-1:0]     w_line;
  logic                  w_process;
  logic                  w_hit;
  logic [AGE_W-1:0]      w_hitIdx;
  logic                  w_freeFound;
  logic [AGE_W-1:0]      w_freeIdx;
  logic [AGE_W-1:0]      w_lruIdx;
  logic [AGE_W-1:0]      w_touchIdx;
  logic [AGE_W-1:0]      w_touchOldAge;
  logic [OFF_W-1:0]      w_hitLastOff;
  logic [STR_W-1:0]      w_hitStride;
  logic [CONF_WIDTH-1:0] w_hitConf;
  logic [STR_W-1:0]      w_delta;
  logic                  w_deltaZero;
  logic                  w_deltaMatch;
  logic [CONF_WIDTH-1:0] w_confInc;
  logic [CONF_WIDTH-1:0] w_thrEff;
  logic                  w_trigger;
  logic [OFF_W+1:0]      w_tgtOff;
  logic                  w_tgtInRange;
  logic [LINE_W-1:0]     w_tgtLine;
  logic                  w_fire;
  logic                  w_unusedByteBits;

  assign w_tag            = snoop_addr_i[ADDR_WIDTH-1:REGION_BITS];
  assign w_off            = snoop_addr_i[REGION_BITS-1:LINE_BITS];
  assign w_line           = snoop_addr_i[ADDR_WIDTH-1:LINE_BITS];
  assign w_unusedByteBits = ^snoop_addr_i[LINE_BITS-1:0];
  assign w_process        = snoop_valid_i && enable_i && !flush_i;

  // Tag lookup, first free slot, and the LRU victim (age == max) in one pass.
  always_comb begin
    w_hit       = 1'b0;
    w_hitIdx    = '0;
    w_freeFound = 1'b0;
    w_freeIdx   = '0;
    w_lruIdx    = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (r_valid[i] && (r_tag[i] == w_tag) && !w_hit) begin
        w_hit    = 1'b1;
        w_hitIdx = AGE_W'(i);
      end
      if (!r_valid[i] && !w_freeFound) begin
        w_freeFound = 1'b1;
        w_freeIdx   = AGE_W'(i);
      end
      if (r_age[i] == AGE_MAX) begin
        w_lruIdx = AGE_W'(i);
      end
    end
  end

  assign w_touchIdx    = w_hit ? w_hitIdx : (w_freeFound ? w_freeIdx : w_lruIdx);
  assign w_touchOldAge = r_valid[w_touchIdx] ? r_age[w_touchIdx] : AGE_MAX;

  assign w_hitLastOff = r_lastOff[w_hitIdx];
  assign w_hitStride  = r_stride[w_hitIdx];
  assign w_hitConf    = r_conf[w_hitIdx];

  // Two's-complement difference of zero-extended offsets gives the signed line delta.
  assign w_delta      = {1'b0, w_off} - {1'b0, w_hitLastOff};
  assign w_deltaZero  = (w_delta == '0);
  assign w_deltaMatch = (w_delta == w_hitStride);
  assign w_confInc    = (w_hitConf == CONF_MAX) ? w_hitConf : w_hitConf + CONF_WIDTH'(1);
  assign w_thrEff     = (conf_threshold_i == '0) ? CONF_WIDTH'(1) : conf_threshold_i;
  assign w_trigger    = w_process && w_hit && !w_deltaZero && w_deltaMatch
                        && (w_confInc >= w_thrEff);

  // Target stays in-region only when the extended offset sum has both top bits clear.
  assign w_tgtOff     = {2'b00, w_off} + {w_hitStride[STR_W-1], w_hitStride};
  assign w_tgtInRange = (w_tgtOff[OFF_W+1:OFF_W] == 2'b00);
  assign w_tgtLine    = w_line + {{(LINE_W-STR_W){w_hitStride[STR_W-1]}}, w_hitStride};
  assign w_fire       = w_trigger && w_tgtInRange;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_valid[i]   <= 1'b0;
        r_tag[i]     <= '0;
        r_lastOff[i] <= '0;
        r_stride[i]  <= '0;
        r_conf[i]    <= '0;
        r_age[i]     <= AGE_W'(i);
      end
    end else if (flush_i) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_age[i]   <= AGE_W'(i);
      end
    end else if (w_process) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (AGE_W'(i) == w_touchIdx) begin
          r_age[i]   <= '0;
          r_valid[i] <= 1'b1;
          if (w_hit) begin
            if (!w_deltaZero) begin
              r_lastOff[i] <= w_off;
              if (w_deltaMatch) begin
                r_conf[i] <= w_confInc;
              end else begin
                r_stride[i] <= w_delta;
                r_conf[i]   <= '0;
              end
            end
          end else begin
            r_tag[i]     <= w_tag;
            r_lastOff[i] <= w_off;
            r_stride[i]  <= '0;
            r_conf[i]    <= '0;
          end
        end else if (r_valid[i] && (r_age[i] < w_touchOldAge)) begin
          r_age[i] <= r_age[i] + AGE_W'(1);
        end
      end
    end
  end

  // One-deep descriptor register; a trigger that finds it occupied and stalled is counted as dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_reqValid  <= 1'b0;
      r_reqBase   <= '0;
      r_reqStride <= '0;
      r_dropCnt   <= '0;
    end else if (w_fire) begin
      if (!r_reqValid || req_ready_i) begin
        r_reqValid  <= 1'b1;
        r_reqBase   <= w_tgtLine;
        r_reqStride <= w_hitStride;
      end else if (r_dropCnt != '1) begin
        r_dropCnt <= r_dropCnt + DROP_CNT_WIDTH'(1);
      end
    end else if (r_reqValid && req_ready_i) begin
      r_reqValid <= 1'b0;
    end
  end

  assign req_valid_o  = r_reqValid;
  assign req_base_o   = r_reqBase;
  assign req_stride_o = r_reqStride;
  assign req_nlines_o = 16'(PF_NLINES);
  assign drop_cnt_o   = r_dropCnt;

endmodule

// File: tb/tb_fetchflare_stride_trainer.sv
// Scoreboard bench: a recency-list reference model predicts descriptors and drops; a negedge
// monitor compares the output port against the expected-descriptor queue every cycle.
module tb_fetchflare_stride_trainer;

  localparam int NUM_ENTRIES = 32;
  localparam int ADDR_WIDTH  = 49;
  localparam int CONF_WIDTH  = 2;
  localparam int CONF_MAX    = (1 << CONF_WIDTH) - 1;
  localparam int DROP_MAX    = 65535;

  logic        clk_i;
  logic        rst_i;
  logic        enable_i;
  logic        flush_i;
  logic [1:0]  conf_threshold_i;
  logic        snoop_valid_i;
  logic [48:0] snoop_addr_i;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [42:0] req_base_o;
  logic [6:0]  req_stride_o;
  logic [15:0] req_nlines_o;
  logic [15:0] drop_cnt_o;

  fetchflare_stride_trainer #(
    .NUM_ENTRIES(NUM_ENTRIES), .ADDR_WIDTH(ADDR_WIDTH), .LINE_BITS(6), .REGION_BITS(12),
    .CONF_WIDTH(CONF_WIDTH), .PF_NLINES(4), .DROP_CNT_WIDTH(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .flush_i(flush_i),
    .conf_threshold_i(conf_threshold_i), .snoop_valid_i(snoop_valid_i),
    .snoop_addr_i(snoop_addr_i), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_base_o(req_base_o), .req_stride_o(req_stride_o), .req_nlines_o(req_nlines_o),
    .drop_cnt_o(drop_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [36:0] tag;
    int          lastOff;
    int          stride;
    int          conf;
  } entry_t;

  typedef struct {
    logic [42:0] base;
    logic [6:0]  stride;
  } desc_t;

  entry_t tbl[$];
  desc_t  expQ[$];
  int     modelDrop;
  int     checks;
  int     failures;
  bit     monEn;
  logic [1:0] thr;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Front of the list is most recently used; eviction takes the back.
  function automatic void modelStep(input logic sv, input logic [48:0] addr, input logic en, input logic fl);
    logic [36:0] tag;
    int          off;
    longint      line;
    int          idx;
    int          d;
    int          tgt;
    bit          fire;
    entry_t      e;
    desc_t       nd;
    if (fl) begin
      tbl.delete();
      return;
    end
    if (!(sv && en)) return;
    tag  = addr[48:12];
    off  = int'(addr[11:6]);
    line = longint'(addr[48:6]);
    idx  = -1;
    foreach (tbl[k]) if (tbl[k].tag == tag) idx = k;
    if (idx >= 0) begin
      e = tbl[idx];
      tbl.delete(idx);
      d = off - e.lastOff;
      fire = 1'b0;
      if (d != 0) begin
        if (d == e.stride) begin
          e.conf = (e.conf < CONF_MAX) ? e.conf + 1 : CONF_MAX;
          fire = (e.conf >= ((thr == 2'd0) ? 1 : int'(thr)));
        end else begin
          e.stride = d;
          e.conf   = 0;
        end
        e.lastOff = off;
      end
      tbl.push_front(e);
      if (fire) begin
        tgt = off + e.stride;
        if (tgt >= 0 && tgt <= 63) begin
          if (expQ.size() == 0) begin
            nd.base   = 43'(line + longint'(e.stride));
            nd.stride = 7'(e.stride);
            expQ.push_back(nd);
          end else if (modelDrop < DROP_MAX) begin
            modelDrop++;
          end
        end
      end
    end else begin
      if (tbl.size() == NUM_ENTRIES) void'(tbl.pop_back());
      e.tag = tag; e.lastOff = off; e.stride = 0; e.conf = 0;
      tbl.push_front(e);
    end
  endfunction

  task automatic applyStimulus(input logic sv, input logic [48:0] addr, input logic rdy,
                               input logic en, input logic fl);
    snoop_valid_i    = sv;
    snoop_addr_i     = addr;
    req_ready_i      = rdy;
    enable_i         = en;
    flush_i          = fl;
    conf_threshold_i = thr;
    @(posedge clk_i);
    modelStep(sv, addr, en, fl);
    #1;
  endtask

  task automatic snoop(input logic [48:0] addr, input logic rdy);
    applyStimulus(1'b1, addr, rdy, 1'b1, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, '0, rdy, 1'b1, 1'b0);
  endtask

  always @(negedge clk_i) begin
    if (monEn && !rst_i) begin
      checkOutput("mon_valid", 64'(req_valid_o), 64'(expQ.size() != 0));
      if (req_valid_o && expQ.size() != 0) begin
        checkOutput("mon_base", 64'(req_base_o), 64'(expQ[0].base));
        checkOutput("mon_stride", 64'(req_stride_o), 64'(expQ[0].stride));
        checkOutput("mon_nlines", 64'(req_nlines_o), 64'd4);
        if (req_ready_i) void'(expQ.pop_front());
      end
      checkOutput("mon_drop", 64'(drop_cnt_o), 64'(modelDrop));
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [36:0] pool[48];
    logic [36:0] sTag[6];
    int          sOff[6];
    int          sStr[6];
    logic [63:0] tmp;
    logic [36:0] tag;
    int          off;
    int          s;
    int          nxt;
    logic        rdy;
    logic        en;
    logic        fl;
    logic        sv;

    checks = 0; failures = 0; modelDrop = 0; monEn = 1'b0; thr = 2'd3;
    rst_i = 1'b1; enable_i = 1'b1; flush_i = 1'b0; conf_threshold_i = thr;
    snoop_valid_i = 1'b0; snoop_addr_i = '0; req_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_valid", 64'(req_valid_o), 64'd0);
    checkOutput("rst_base", 64'(req_base_o), 64'd0);
    checkOutput("rst_stride", 64'(req_stride_o), 64'd0);
    checkOutput("rst_nlines", 64'(req_nlines_o), 64'd4);
    checkOutput("rst_drop", 64'(drop_cnt_o), 64'd0);
    #2 rst_i = 1'b0;
    @(posedge clk_i);
    #1 monEn = 1'b1;

    $display("[TB] positive stride");
    for (int k = 0; k < 5; k++) snoop(49'h1000 + 49'(k * 'h40), 1'b1);
    checkOutput("t1_valid", 64'(req_valid_o), 64'd1);
    checkOutput("t1_base", 64'(req_base_o), 64'h45);
    checkOutput("t1_stride", 64'(req_stride_o), 64'h01);
    checkOutput("t1_nlines", 64'(req_nlines_o), 64'd4);
    repeat (2) idle(1'b1);

    $display("[TB] negative stride");
    for (int k = 0; k < 5; k++) snoop(49'h2FC0 - 49'(k * 'h80), 1'b1);
    checkOutput("t2_base", 64'(req_base_o), 64'hB5);
    checkOutput("t2_stride", 64'(req_stride_o), 64'h7E);
    repeat (2) idle(1'b1);

    $display("[TB] region-cross suppression");
    for (int k = 0; k < 5; k++) snoop(49'h1D80 + 49'(k * 'h80), 1'b1);
    snoop(49'h1F80, 1'b1);
    idle(1'b1);
    checkOutput("t3_valid", 64'(req_valid_o), 64'd0);
    checkOutput("t3_drop", 64'(drop_cnt_o), 64'd0);

    $display("[TB] backpressure");
    for (int k = 0; k < 5; k++) begin
      snoop(49'h5000 + 49'(k * 'h40), 1'b0);
      snoop(49'h6000 + 49'((10 + 2 * k) * 'h40), 1'b0);
    end
    checkOutput("t4_held_base", 64'(req_base_o), 64'h145);
    checkOutput("t4_drop", 64'(drop_cnt_o), 64'd1);
    for (int k = 0; k < 4; k++) snoop(49'h7000 + 49'((32 - k) * 'h40), 1'b0);
    snoop(49'h7000 + 49'(28 * 'h40), 1'b1);
    checkOutput("t4_reload_valid", 64'(req_valid_o), 64'd1);
    checkOutput("t4_reload_base", 64'(req_base_o), 64'h1DB);
    checkOutput("t4_reload_stride", 64'(req_stride_o), 64'h7F);
    repeat (2) idle(1'b1);

    $display("[TB] LRU eviction");
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) snoop(49'(k * 'h40), 1'b1);
    for (int r = 1; r < 32; r++) snoop(49'(r) << 12, 1'b1);
    snoop(49'h00C0, 1'b1);
    snoop(49'h20000, 1'b1);
    snoop(49'h0100, 1'b1);
    checkOutput("t5_valid", 64'(req_valid_o), 64'd1);
    checkOutput("t5_base", 64'(req_base_o), 64'h5);
    repeat (2) idle(1'b1);

    $display("[TB] flush and reset");
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) snoop(49'h9000 + 49'(k * 'h40), 1'b0);
    applyStimulus(1'b1, 49'h9100, 1'b0, 1'b1, 1'b1);
    for (int k = 5; k < 10; k++) snoop(49'h9000 + 49'(k * 'h40), 1'b0);
    checkOutput("t6_base", 64'(req_base_o), 64'h24A);
    idle(1'b0);
    monEn = 1'b0;
    rst_i = 1'b1;
    #1;
    checkOutput("t6_rst_valid", 64'(req_valid_o), 64'd0);
    checkOutput("t6_rst_drop", 64'(drop_cnt_o), 64'd0);
    tbl.delete(); expQ.delete(); modelDrop = 0;
    #2 rst_i = 1'b0;
    @(posedge clk_i);
    #1 monEn = 1'b1;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 48; i++) begin
      tmp = {$urandom(), $urandom()};
      pool[i] = tmp[36:0];
    end
    for (int i = 0; i < 6; i++) begin
      sTag[i] = pool[i];
      sOff[i] = int'($urandom_range(0, 63));
      sStr[i] = int'($urandom_range(0, 6)) - 3;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) thr = 2'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 1) != 0);
      en  = ($urandom_range(0, 15) != 0);
      fl  = ($urandom_range(0, 127) == 0);
      sv  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        tag = pool[$urandom_range(0, 47)];
        off = int'($urandom_range(0, 63));
      end else begin
        s = int'($urandom_range(0, 5));
        if ($urandom_range(0, 15) == 0) sStr[s] = int'($urandom_range(0, 6)) - 3;
        nxt = sOff[s] + sStr[s];
        if (nxt < 0 || nxt > 63) nxt = int'($urandom_range(0, 63));
        sOff[s] = nxt;
        tag = sTag[s];
        off = nxt;
      end
      applyStimulus(sv, {tag, 6'(off), 6'($urandom_range(0, 63))}, rdy, en, fl);
    end

    repeat (3) idle(1'b1);
    checkOutput("end_valid", 64'(req_valid_o), 64'd0);
    checkOutput("end_drop", 64'(drop_cnt_o), 64'(modelDrop));
    monEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetchflare_stride_trainer.md
Name: fetchflare_stride_trainer

Overview:
Parametrised successor to the fixed INITIAL/HIT1..3/PREFETCHING stride training table. It snoops demand-miss addresses and tracks one stream per memory region in a fully-associative table with age-based LRU replacement. Each entry holds a signed line stride and a saturating confidence counter. When confidence reaches a programmable threshold, the block emits one prefetch descriptor (base line, stride, nlines) over a valid/ready port to the prefetch-engine queue.

Parameters:
NUM_ENTRIES, 32, table entries (power of 2, >=2)
ADDR_WIDTH, 49, physical byte-address width
LINE_BITS, 6, log2 cache-line bytes
REGION_BITS, 12, log2 region bytes; tag = addr[ADDR_WIDTH-1:REGION_BITS]
CONF_WIDTH, 2, confidence counter width
PF_NLINES, 4, nlines field of every emitted request
DROP_CNT_WIDTH, 16, dropped-trigger counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
enable_i  in  1  training enable
flush_i  in  1  invalidate whole table (one-cycle pulse)
conf_threshold_i  in  CONF_WIDTH  trigger threshold (0 treated as 1)
snoop_valid_i  in  1  snooped access valid (always accepted)
snoop_addr_i  in  ADDR_WIDTH  snooped byte address
req_valid_o  out  1  prefetch descriptor valid
req_ready_i  in  1  engine queue accepts descriptor
req_base_o  out  ADDR_WIDTH-LINE_BITS  first line address to prefetch
req_stride_o  out  REGION_BITS-LINE_BITS+1  signed stride in lines
req_nlines_o  out  16  = PF_NLINES
drop_cnt_o  out  DROP_CNT_WIDTH  saturating count of dropped triggers

Behaviour:
- Reset (async, rst_i=1): all entries invalid, ages[i]=i, req_valid_o=0, req_base_o=0, req_stride_o=0, req_nlines_o=PF_NLINES, drop_cnt_o=0. Asserting reset mid-operation discards pending request and table.
- Entry fields: valid, tag, last_off (line offset in region, REGION_BITS-LINE_BITS bits), stride (signed, REGION_BITS-LINE_BITS+1 bits), conf, age (log2 NUM_ENTRIES bits).
- Snoop is processed only when snoop_valid_i && enable_i && !flush_i. Lookup is a combinational tag compare. The table updates on the same clock edge.
- Hit, with d = off - last_off (signed):
  - d==0: no change to stride, conf or last_off. Age is still refreshed.
  - d==stride: conf saturating-increments.
  - otherwise: stride<=d, conf<=0.
  - last_off<=off.
- Trigger condition: hit, d!=0, d==stride, and the post-increment conf >= max(conf_threshold_i, 1).
- Miss: allocate the lowest-index invalid entry. If none is invalid, replace the entry with age==NUM_ENTRIES-1. New entry: valid=1, tag, last_off=off, stride=0, conf=0.
- LRU on each hit or allocate: the touched entry's age<=0. Every valid entry whose age is below the touched entry's old age increments by 1. Ages remain a permutation. Invalid entries are treated as age NUM_ENTRIES-1 for the compare.
- Target line = snoop line + stride. If the target's region offset falls outside [0, 2^(REGION_BITS-LINE_BITS)-1], the trigger is suppressed: no request, no drop count.
- Output register (1 deep): req_valid_o rises the cycle after the trigger edge, with req_base_o=target line and req_stride_o=stride.
- Handshake: transfer occurs on req_valid_o && req_ready_i. Outputs are held stable while valid && !ready.
- Trigger while valid && !ready: the new trigger is dropped and drop_cnt_o increments, saturating at all-ones.
- Trigger in the same cycle as a transfer: the new descriptor is loaded and valid stays 1.
- enable_i=0: table frozen, snoops ignored. A pending request still drains.
- flush_i: next edge invalidates all entries and sets ages[i]=i. Flush wins over a same-cycle snoop. The output register and drop_cnt_o are unaffected.

Test Plan:
1. Positive stride (threshold=3): snoop 0x1000, 0x1040, 0x1080, 0x10C0, 0x1100, ready=1 -> exactly one request, one cycle after the 5th snoop, with req_base_o=0x45 (line of 0x1140), req_stride_o=+1, req_nlines_o=4.
2. Negative stride (threshold=3): snoop 0x2FC0, 0x2F40, 0x2EC0, 0x2E40, 0x2DC0 -> req_base_o=0xB5 (line of 0x2D40), req_stride_o=-2.
3. Region-cross suppression: snoop 0x1D80, 0x1E00, 0x1E80, 0x1F00, 0x1F80 (stride +2, target 0x2000) -> req_valid_o stays 0 and drop_cnt_o=0. A 6th snoop at 0x1F80 (d=0) also produces no request.
4. Backpressure: hold req_ready_i=0 and drive two streams to trigger on consecutive cycles -> first descriptor held stable, drop_cnt_o=1. Raise ready with a third trigger in the same cycle -> first transferred, third loaded, valid stays 1.
5. LRU eviction (NUM_ENTRIES=32): touch regions 0x0000..0x1F000 once each, re-touch 0x0000, then touch 0x20000 -> the 0x1000 entry is replaced. A following 0x0000 snoop hits and keeps its last_off.
6. Flush/reset: train stream to conf=2, pulse flush_i together with a snoop -> snoop ignored and the next snoop misses with conf=0. Assert rst_i mid-request -> req_valid_o drops immediately and drop_cnt_o=0.
